uart_tx_scheduler: RTL

Buffers and paces byte writes from the CPU store path to the UART transmitter. The core issues at most one byte store per cycle, but the UART transmitter has no busy/ready output and needs about 10 bit-times per byte. This block queues bytes in a small FIFO and launches each one as a single-cycle write strobe, with consecutive strobes spaced a fixed number of cycles apart. It sits between the memory stage's UART write decode and the uart instance.

---
 rtl/uart_tx_scheduler_pkg.sv | 17 +
 rtl/uart_tx_fifo.sv | 61 ++++++
 rtl/uart_tx_scheduler.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART transmit pacing block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_scheduler_pkg;

    // Pacing FSM states.
    typedef enum logic [1:0] {
        UTS_IDLE = 2'd0,
        UTS_SEND = 2'd1,
        UTS_GAP  = 2'd2
    } uts_state_t;

    localparam int UTS_DEF_DEPTH      = 16;
    localparam int UTS_DEF_GAP_CYCLES = 8700;   // 10 bits at 115200 baud on a 100 MHz clock
    localparam int UTS_DAT_W          = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the store path and the pacing FSM.
// Latency: a pushed byte is visible at head_dat the cycle after the push.
// Backpressure: none upstream; push when full is accepted only with a same-edge pop, otherwise push_ok=0.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   push_ok
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = mem[rd_ptr];

    // Storage array: written only on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues CPU byte stores and launches them to the UART as one-cycle strobes spaced GAP_CYCLES apart.
// Latency: byte written into an idle, empty block strobes out the cycle after the following edge.
// Backpressure: none; writes arriving while full (and no pop) are dropped and set the sticky ovf_o.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int  DEPTH      = UTS_DEF_DEPTH,
    parameter int  GAP_CYCLES = UTS_DEF_GAP_CYCLES,
    localparam int CNT_W      = $clog2(GAP_CYCLES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   uart_wr_o,
    output logic [7:0]             uart_dat_o,
    input  logic                   ovf_clr,
    output logic                   ovf_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   idle_o
);
    uts_state_t     state;
    logic [CNT_W-1:0] gap_cnt;
    logic           pop;
    logic           push_ok;
    logic           fifo_empty;
    logic [7:0]     head_dat;

    // Pop decision depends only on registered state so outputs have no input-to-output path.
    assign pop    = !fifo_empty &&
                    ((state == UTS_IDLE) || ((state == UTS_GAP) && (gap_cnt == '0)));
    assign idle_o = fifo_empty && (state == UTS_IDLE);

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .W     (UTS_DAT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .push_dat (wr_data),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count_o),
        .full     (full_o),
        .empty    (fifo_empty),
        .push_ok  (push_ok)
    );

    // Pacing FSM: strobe for one cycle, then hold off for the rest of the gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= UTS_IDLE;
            gap_cnt    <= '0;
            uart_wr_o  <= 1'b0;
            uart_dat_o <= 8'h00;
        end else begin
            case (state)
                UTS_IDLE: begin
                    uart_wr_o <= 1'b0;
                    if (pop) begin
                        state      <= UTS_SEND;
                        uart_wr_o  <= 1'b1;
                        uart_dat_o <= head_dat;
                    end
                end
                UTS_SEND: begin
                    // SEND and the GAP countdown together span exactly GAP_CYCLES edges.
                    uart_wr_o <= 1'b0;
                    gap_cnt   <= CNT_W'(GAP_CYCLES - 2);
                    state     <= UTS_GAP;
                end
                UTS_GAP: begin
                    uart_wr_o <= 1'b0;
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end else if (pop) begin
                        state      <= UTS_SEND;
                        uart_wr_o  <= 1'b1;
                        uart_dat_o <= head_dat;
                    end else begin
                        state <= UTS_IDLE;
                    end
                end
                default: begin
                    state     <= UTS_IDLE;
                    uart_wr_o <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a dropped write beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_o <= 1'b0;
        end else if (wr_en && !push_ok) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr) begin
            ovf_o <= 1'b0;
        end
    end

endmodule
